rtc_div_ctrl: RTL

RTC_DIV_CTRL -- requirements
Module: rtc_div_ctrl

---
 rtl/rtc_div_pkg.sv | 22 ++
 rtl/rtc_div_cnt.sv | 65 ++++++
 rtl/rtc_div_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/rtc_div_pkg.sv
//------------------------------------------------------------------------------
// Module      : rtc_div_pkg
// Description : Shared state encoding and default constants for rtc_div_ctrl.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package rtc_div_pkg;

    localparam int c_DIV_W   = 16;
    localparam int c_DEF_DIV = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2,
        ST_STOP = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/rtc_div_cnt.sv
//------------------------------------------------------------------------------
// Module      : rtc_div_cnt
// Description : Period counter, phase compare and tick generation. Holds the
//               ratio in effect; i_load replaces it (idle or period boundary).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rtc_div_cnt
    import rtc_div_pkg::*;
#(
    parameter int DIV_W   = c_DIV_W,
    parameter int DEF_DIV = c_DEF_DIV
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_load,
    input  logic [DIV_W-1:0] i_load_div,
    output logic             o_boundary,
    output logic             o_pclk,
    output logic             o_tick,
    output logic [DIV_W-1:0] o_div
);

    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_div;
    logic             r_pclk;
    logic             r_tick;

    logic             w_boundary;
    logic [DIV_W-1:0] w_cnt_nxt;
    logic [DIV_W-1:0] w_half_nxt;

    always_comb begin
        w_boundary = i_en && (r_cnt == (r_div - DIV_W'(1)));
        w_cnt_nxt  = (!i_en || w_boundary) ? '0 : (r_cnt + DIV_W'(1));
        // Phase is decided against the ratio that governs the next cycle.
        w_half_nxt = (i_load ? i_load_div : r_div) >> 1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_div  <= DIV_W'(DEF_DIV);
            r_pclk <= 1'b0;
            r_tick <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_pclk <= (w_cnt_nxt >= w_half_nxt);
            r_tick <= (w_cnt_nxt == w_half_nxt);
            if (i_load) begin
                r_div <= i_load_div;
            end
        end
    end

    assign o_boundary = w_boundary;
    assign o_pclk     = r_pclk;
    assign o_tick     = r_tick;
    assign o_div      = r_div;

endmodule

`default_nettype wire

// File: rtl/rtc_div_ctrl.sv
//------------------------------------------------------------------------------
// Module      : rtc_div_ctrl
// Description : Run/stop FSM and ratio handshake for a glitch-free clock
//               divider. Define RTC_DIV_ODD_EN to allow odd divide ratios.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rtc_div_ctrl
    import rtc_div_pkg::*;
#(
    parameter int DIV_W   = c_DIV_W,
    parameter int DEF_DIV = c_DEF_DIV
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             cfg_valid,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             pclk,
    output logic             tick,
    output logic             busy,
    output logic [DIV_W-1:0] cur_div
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [DIV_W-1:0] r_held;
    logic             r_pend;
    logic             r_cfg_err;

    logic [DIV_W-1:0] w_norm_div;
    logic             w_div_ok;
    logic             w_xfer;
    logic             w_hold;
    logic             w_set_idle;
    logic             w_apply;
    logic             w_pend_nxt;
    logic             w_boundary;
    logic             w_load;
    logic [DIV_W-1:0] w_load_div;

    always_comb begin
`ifdef RTC_DIV_ODD_EN
        w_norm_div = cfg_div;
`else
        w_norm_div = cfg_div & ~DIV_W'(1);
`endif
    end

    always_comb begin
        cfg_ready  = (r_state == ST_IDLE) || (r_state == ST_RUN);
        w_xfer     = cfg_valid && cfg_ready;
        w_div_ok   = (w_norm_div >= DIV_W'(2));
        w_hold     = w_xfer && w_div_ok && (r_state == ST_RUN);
        w_set_idle = w_xfer && w_div_ok && (r_state == ST_IDLE);
        w_apply    = r_pend && w_boundary;
        // A ratio accepted on a boundary cycle waits for the following one.
        w_pend_nxt = (r_pend && !w_boundary) || w_hold;
        w_load     = w_set_idle || w_apply;
        w_load_div = w_apply ? r_held : w_norm_div;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (run) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!run) begin
                    w_state_nxt = ST_STOP;
                end else if (w_hold) begin
                    w_state_nxt = ST_PEND;
                end
            end
            ST_PEND: begin
                if (!run) begin
                    w_state_nxt = ST_STOP;
                end else if (w_boundary) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_STOP: begin
                if (run) begin
                    w_state_nxt = w_pend_nxt ? ST_PEND : ST_RUN;
                end else if (w_boundary) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_held    <= '0;
            r_pend    <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pend    <= w_pend_nxt;
            r_cfg_err <= w_xfer && !w_div_ok;
            if (w_hold) begin
                r_held <= w_norm_div;
            end
        end
    end

    rtc_div_cnt #(
        .DIV_W   (DIV_W),
        .DEF_DIV (DEF_DIV)
    ) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_en       (r_state != ST_IDLE),
        .i_load     (w_load),
        .i_load_div (w_load_div),
        .o_boundary (w_boundary),
        .o_pclk     (pclk),
        .o_tick     (tick),
        .o_div      (cur_div)
    );

    assign cfg_err = r_cfg_err;
    assign busy    = (r_state != ST_IDLE);

endmodule

`default_nettype wire
